// File: rtl/divider32_seq.sv
// Iterative unsigned restoring divider: one quotient bit per clock, MSB first.
// Start/busy/done handshake; results hold until the next completion or reset.
module divider32_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;

    // Dividend bits shift out of the MSB while quotient bits shift in at the LSB.
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] prem_q;

    logic [WIDTH-1:0] dvd_d;
    logic [WIDTH-1:0] prem_d;
    logic             qbit_d;
    logic             last_iter;

    // The shifted remainder is below 2*divisor, so the sign of the
    // (WIDTH+1)-bit difference is exactly the restoring decision.
    function automatic logic [WIDTH:0] div_step(
        input logic [WIDTH-1:0] prem,
        input logic             nbit,
        input logic [WIDTH-1:0] dvs
    );
        logic [WIDTH:0] shifted;
        logic [WIDTH:0] diff;
        shifted = {prem, nbit};
        diff    = shifted - {1'b0, dvs};
        if (diff[WIDTH]) begin
            div_step = {1'b0, shifted[WIDTH-1:0]};
        end else begin
            div_step = {1'b1, diff[WIDTH-1:0]};
        end
    endfunction

    always_comb begin
        {qbit_d, prem_d} = div_step(prem_q, dvd_q[WIDTH-1], dvs_q);
        dvd_d            = {dvd_q[WIDTH-2:0], qbit_d};
        last_iter        = (cnt_q == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        if (operand2 != '0) begin
                            dvd_q   <= operand1;
                            dvs_q   <= operand2;
                            prem_q  <= '0;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end else begin
                            quo_q   <= '1;
                            rem_q   <= operand1;
                            dbz_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    dvd_q  <= dvd_d;
                    prem_q <= prem_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        quo_q   <= dvd_d;
                        rem_q   <= prem_d;
                        dbz_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider32_seq.sv
// Directed and random checks of divider32_seq against a / and % reference,
// with expected results queued at issue and popped on each done pulse.
module tb_divider32_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    divider32_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .operand1    (op1),
        .operand2    (op2),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
            e.z = 1'b1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit push);
        op1   = a;
        op2   = b;
        start = 1'b1;
        if (push) sbq.push_back(model(a, b));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int cyc, output int bcnt);
        exp_t e;
        cyc  = 0;
        bcnt = 0;
        while (!done && cyc < budget) begin
            if (busy) bcnt++;
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done_seen"}, 64'(done), 64'd1);
        if (done) begin
            check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
            check({tag, "_sb_nonempty"}, 64'(sbq.size() != 0), 64'd1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                check({tag, "_quotient"}, 64'(quotient), 64'(e.q));
                check({tag, "_remainder"}, 64'(remainder), 64'(e.r));
                check({tag, "_dbz"}, 64'(div_by_zero), 64'(e.z));
            end
        end
    endtask

    initial begin
        int          cyc;
        int          bcnt;
        int          seen;
        logic [31:0] a;
        logic [31:0] b;
        int unsigned sel;

        rst   = 1'b1;
        start = 1'b0;
        op1   = 32'd0;
        op2   = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_quotient", 64'(quotient), 64'd0);
        check("rst_remainder", 64'(remainder), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // 100 / 7: busy for 32 cycles, done one cycle after E32
        issue(32'd100, 32'd7, 1'b1);
        wait_done("t100_7", 40, cyc, bcnt);
        check("t100_7_latency", 64'(cyc), 64'd32);
        check("t100_7_busy_cycles", 64'(bcnt), 64'd32);
        @(negedge clk);
        check("t100_7_done_pulse", 64'(done), 64'd0);
        check("t100_7_hold_q", 64'(quotient), 64'd14);

        issue(32'hFFFF_FFFF, 32'd1, 1'b1);
        wait_done("tmax_1", 40, cyc, bcnt);
        @(negedge clk);
        issue(32'd5, 32'd9, 1'b1);
        wait_done("t5_9", 40, cyc, bcnt);
        @(negedge clk);

        // divide by zero completes straight away
        issue(32'h1234, 32'd0, 1'b1);
        check("tdbz_busy", 64'(busy), 64'd0);
        wait_done("tdbz", 40, cyc, bcnt);
        check("tdbz_latency", 64'(cyc), 64'd0);
        @(negedge clk);
        check("tdbz_done_pulse", 64'(done), 64'd0);

        // start while busy is ignored, operand changes during RUN ignored
        issue(32'd1000, 32'd10, 1'b1);
        repeat (5) @(negedge clk);
        op1   = 32'd9;
        op2   = 32'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op1   = $urandom;
        op2   = $urandom;
        wait_done("tign", 40, cyc, bcnt);
        check("tign_latency", 64'(cyc), 64'd26);
        @(negedge clk);
        check("tign_no_second", 64'(done), 64'd0);

        // reset during RUN aborts without done
        issue(32'd50000, 32'd3, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("tabort_busy", 64'(busy), 64'd0);
        check("tabort_done", 64'(done), 64'd0);
        check("tabort_quotient", 64'(quotient), 64'd0);
        check("tabort_remainder", 64'(remainder), 64'd0);
        check("tabort_dbz", 64'(div_by_zero), 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("tabort_quiet", 64'(seen), 64'd0);
        issue(32'd9, 32'd4, 1'b1);
        wait_done("t9_4", 40, cyc, bcnt);
        @(negedge clk);

        // back-to-back: start held through the DONE cycle
        issue(32'd200, 32'd9, 1'b1);
        wait_done("tb2b_first", 40, cyc, bcnt);
        issue(32'd77, 32'd8, 1'b1);
        check("tb2b_busy", 64'(busy), 64'd1);
        check("tb2b_hold_q", 64'(quotient), 64'd22);
        check("tb2b_hold_r", 64'(remainder), 64'd2);
        wait_done("tb2b_second", 40, cyc, bcnt);
        check("tb2b_latency", 64'(cyc + 1), 64'd33);
        @(negedge clk);

        for (int i = 0; i < 1000; i++) begin
            a   = $urandom;
            sel = $urandom_range(0, 9);
            case (sel)
                0:       b = 32'd0;
                1:       b = 32'd1;
                2, 3, 4: b = 32'($urandom_range(1, 255));
                5:       b = (a == 32'hFFFF_FFFF) ? a : a + 32'd1;
                6:       begin a = 32'd0; b = $urandom; end
                default: b = $urandom;
            endcase
            issue(a, b, 1'b1);
            wait_done("trand", 40, cyc, bcnt);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
